ready_wait_controller: RTL and testbench



---
 rtl/ready_wait_controller.sv | 197 +++++++++++++++++++
 tb/tb_ready_wait_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ready_wait_controller.sv
// READY generator for the 8088: per-cycle-type wait states, masked ready sources,
// sync/async ready capture and a bus-hang timeout with sticky culprit report.
module ready_wait_controller #(
    parameter int unsigned NUM_SOURCES  = 3,
    parameter int unsigned IO_WAITS     = 1,
    parameter int unsigned MEM_WAITS    = 0,
    parameter int unsigned INTA_WAITS   = 1,
    parameter int unsigned TIMEOUT_CLKS = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cpu_clock_posedge,
    input  logic                   cpu_clock_negedge,
    input  logic                   INTA_N,
    input  logic                   IO_OR_M,
    input  logic                   DEN_N,
    input  logic                   IOR_N,
    input  logic                   IOW_N,
    input  logic [NUM_SOURCES-1:0] ready_in,
    input  logic [NUM_SOURCES-1:0] ready_mask,
    input  logic                   async_mode,
    output logic                   RDY,
    output logic                   wait_active,
    output logic                   timeout_pulse,
    output logic [NUM_SOURCES-1:0] timeout_sources
);

    localparam int unsigned WCNT_W = 4;
    localparam int unsigned TCNT_W = 16;

    localparam logic [WCNT_W-1:0] IO_WCNT   = WCNT_W'(IO_WAITS);
    localparam logic [WCNT_W-1:0] MEM_WCNT  = WCNT_W'(MEM_WAITS);
    localparam logic [WCNT_W-1:0] INTA_WCNT = WCNT_W'(INTA_WAITS);
    localparam logic [TCNT_W-1:0] TCNT_LIM  = TCNT_W'(TIMEOUT_CLKS);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIXED = 2'd1,
        ST_WAIT_EXT   = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CYC_IO   = 2'd0,
        CYC_MEM  = 2'd1,
        CYC_INTA = 2'd2
    } cyc_e;

    state_e                 state_q, state_d;
    cyc_e                   cyc_q, cyc_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   s1_q, s1_d;
    logic                   s2_q, s2_d;
    logic                   async_q, async_d;
    logic                   rdy_q, rdy_d;
    logic                   wait_active_q, wait_active_d;
    logic                   timeout_pulse_q, timeout_pulse_d;
    logic [NUM_SOURCES-1:0] timeout_sources_q, timeout_sources_d;

    logic                   comb_ready;
    logic                   bus_idle;
    logic                   rdy_src;
    cyc_e                   cyc_new;
    logic [WCNT_W-1:0]      waits_new;
    logic [TCNT_W-1:0]      tcnt_inc;
    logic [WCNT_W-1:0]      wcnt_dec;

    // Helper terms: combined ready, bus state, classification, saturating counters
    always_comb begin
        comb_ready = &(ready_in | ~ready_mask);
        bus_idle   = INTA_N & DEN_N & IOR_N & IOW_N;
        rdy_src    = async_q ? s2_q : s1_q;
        tcnt_inc   = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + TCNT_W'(1);
        wcnt_dec   = (wcnt_q == '0) ? wcnt_q : wcnt_q - WCNT_W'(1);

        if (!INTA_N) begin
            cyc_new   = CYC_INTA;
            waits_new = INTA_WCNT;
        end else if (!IOR_N || !IOW_N || (!DEN_N && !IO_OR_M)) begin
            cyc_new   = CYC_IO;
            waits_new = IO_WCNT;
        end else begin
            cyc_new   = CYC_MEM;
            waits_new = MEM_WCNT;
        end
    end

    // Next-state and output logic; the posedge slot is resolved before the RDY update
    always_comb begin
        state_d           = state_q;
        cyc_d             = cyc_q;
        wcnt_d            = wcnt_q;
        tcnt_d            = tcnt_q;
        s1_d              = s1_q;
        s2_d              = s2_q;
        async_d           = async_q;
        rdy_d             = rdy_q;
        timeout_pulse_d   = 1'b0;
        timeout_sources_d = timeout_sources_q;

        if (cpu_clock_posedge) begin
            s1_d = comb_ready;
            s2_d = s1_q;
            if (state_q == ST_IDLE) begin
                async_d = async_mode;
            end

            if (bus_idle) begin
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        cyc_d  = cyc_new;
                        wcnt_d = waits_new;
                        if (waits_new != '0) begin
                            state_d = ST_WAIT_FIXED;
                        end else if (cyc_new == CYC_INTA) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT_EXT;
                        end
                    end
                    ST_WAIT_FIXED: begin
                        wcnt_d = wcnt_dec;
                        if (wcnt_q <= WCNT_W'(1)) begin
                            state_d = (cyc_q == CYC_INTA) ? ST_DONE : ST_WAIT_EXT;
                        end
                    end
                    ST_WAIT_EXT: begin
                        tcnt_d = tcnt_inc;
                        if (rdy_src) begin
                            state_d = ST_DONE;
                        end else if (tcnt_inc >= TCNT_LIM) begin
                            state_d           = ST_DONE;
                            timeout_pulse_d   = 1'b1;
                            timeout_sources_d = ~ready_in & ready_mask;
                        end
                    end
                    ST_DONE: begin
                        state_d = ST_DONE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            if (state_d == ST_IDLE) begin
                tcnt_d = '0;
                wcnt_d = '0;
            end
        end

        // state_d equals state_q when no posedge strobe is present this clock
        if (cpu_clock_negedge) begin
            rdy_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        end

        wait_active_d = (state_d == ST_WAIT_FIXED) || (state_d == ST_WAIT_EXT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            cyc_q             <= CYC_IO;
            wcnt_q            <= '0;
            tcnt_q            <= '0;
            s1_q              <= 1'b1;
            s2_q              <= 1'b1;
            async_q           <= 1'b0;
            rdy_q             <= 1'b1;
            wait_active_q     <= 1'b0;
            timeout_pulse_q   <= 1'b0;
            timeout_sources_q <= '0;
        end else begin
            state_q           <= state_d;
            cyc_q             <= cyc_d;
            wcnt_q            <= wcnt_d;
            tcnt_q            <= tcnt_d;
            s1_q              <= s1_d;
            s2_q              <= s2_d;
            async_q           <= async_d;
            rdy_q             <= rdy_d;
            wait_active_q     <= wait_active_d;
            timeout_pulse_q   <= timeout_pulse_d;
            timeout_sources_q <= timeout_sources_d;
        end
    end

    assign RDY             = rdy_q;
    assign wait_active     = wait_active_q;
    assign timeout_pulse   = timeout_pulse_q;
    assign timeout_sources = timeout_sources_q;

endmodule

// File: tb/tb_ready_wait_controller.sv
// Bench for ready_wait_controller: table of bus cycles measured against a queue of
// expected RDY-low lengths, plus hand sequences for bus abort and reset mid-wait.
module tb_ready_wait_controller;

    localparam int unsigned NS      = 3;
    localparam int          CPU_DIV = 4;

    localparam int K_IDLE = -1;
    localparam int K_IOR  = 0;
    localparam int K_IOW  = 1;
    localparam int K_MEM  = 2;
    localparam int K_INTA = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cpu_clock_posedge;
    logic          cpu_clock_negedge;
    logic          INTA_N, IO_OR_M, DEN_N, IOR_N, IOW_N;
    logic [NS-1:0] ready_in;
    logic [NS-1:0] ready_mask;
    logic          async_mode;
    logic          RDY, wait_active, timeout_pulse;
    logic [NS-1:0] timeout_sources;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [2:0]  rdy;
        logic [2:0]  mask;
        logic        amode;
        int          rel_after;
        int          low_cpu;
        int          pulses;
        logic [2:0]  ts;
    } vec_t;

    typedef struct {
        int          low_clk;
        int          wait_clk;
        int          pulses;
        logic [2:0]  ts;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    ready_wait_controller #(
        .NUM_SOURCES (NS),
        .IO_WAITS    (1),
        .MEM_WAITS   (0),
        .INTA_WAITS  (1),
        .TIMEOUT_CLKS(8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_clock_posedge(cpu_clock_posedge),
        .cpu_clock_negedge(cpu_clock_negedge),
        .INTA_N           (INTA_N),
        .IO_OR_M          (IO_OR_M),
        .DEN_N            (DEN_N),
        .IOR_N            (IOR_N),
        .IOW_N            (IOW_N),
        .ready_in         (ready_in),
        .ready_mask       (ready_mask),
        .async_mode       (async_mode),
        .RDY              (RDY),
        .wait_active      (wait_active),
        .timeout_pulse    (timeout_pulse),
        .timeout_sources  (timeout_sources)
    );

    initial forever #5 clock = ~clock;

    // CPU clock = 4 system clocks: rising-edge slot at phase 0, falling-edge slot at phase 2
    initial begin
        int ph;
        ph = 3;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % CPU_DIV;
            cpu_clock_posedge = (ph == 0);
            cpu_clock_negedge = (ph == 2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Return just after the falling-edge slot, i.e. mid CPU clock
    task automatic wait_mid();
        do @(posedge clock); while (!cpu_clock_negedge);
        #1;
    endtask

    task automatic drive_bus(input int kind);
        INTA_N  = 1'b1;
        IO_OR_M = 1'b0;
        DEN_N   = 1'b1;
        IOR_N   = 1'b1;
        IOW_N   = 1'b1;
        case (kind)
            K_IOR:   begin IOR_N = 1'b0; DEN_N = 1'b0; end
            K_IOW:   begin IOW_N = 1'b0; DEN_N = 1'b0; end
            K_MEM:   begin DEN_N = 1'b0; IO_OR_M = 1'b1; end
            K_INTA:  INTA_N = 1'b0;
            default: ;
        endcase
    endtask

    function automatic vec_t mk(input int kind, input logic [2:0] rdy, input logic [2:0] mask,
                                input logic am, input int rel, input int low, input int pul,
                                input logic [2:0] ts);
        vec_t v;
        v.kind = kind; v.rdy = rdy; v.mask = mask; v.amode = am;
        v.rel_after = rel; v.low_cpu = low; v.pulses = pul; v.ts = ts;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   low, wa, pulses, npos;
        bit   seen, done;
        wait_mid();
        ready_in   = v.rdy;
        ready_mask = v.mask;
        async_mode = v.amode;
        wait_mid();
        e.low_clk  = v.low_cpu * CPU_DIV;
        e.wait_clk = v.low_cpu * CPU_DIV;
        e.pulses   = v.pulses;
        e.ts       = v.ts;
        sb.push_back(e);
        drive_bus(v.kind);
        low = 0; wa = 0; pulses = 0; npos = 0; seen = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clock);
            #1;
            if (cpu_clock_posedge) begin
                npos++;
                if (npos == v.rel_after) ready_in = '1;
            end
            if (!RDY) begin
                low++;
                seen = 1'b1;
            end
            if (wait_active) wa++;
            if (timeout_pulse) pulses++;
            if (seen && RDY) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_complete: RDY low-then-high not seen in 400 clocks (seen_low=%0d)", idx, seen);
        end
        drive_bus(K_IDLE);
        e = sb.pop_front();
        chk($sformatf("vec%0d_rdy_low_clks", idx), low, e.low_clk);
        chk($sformatf("vec%0d_wait_active_clks", idx), wa, e.wait_clk);
        chk($sformatf("vec%0d_timeout_pulses", idx), pulses, e.pulses);
        chk($sformatf("vec%0d_timeout_sources", idx), int'(timeout_sources), int'(e.ts));
        wait_mid();
        wait_mid();
    endtask

    initial begin
        int pulses;

        // kind, ready_in, mask, async, release-after-posedges, RDY-low CPU clocks, pulses, sources
        vecs[0] = mk(K_IOR,  3'b111, 3'b111, 1'b0, 0, 2, 0, 3'b000);
        vecs[1] = mk(K_MEM,  3'b101, 3'b111, 1'b1, 5, 7, 0, 3'b000);
        vecs[2] = mk(K_MEM,  3'b101, 3'b111, 1'b0, 5, 6, 0, 3'b000);
        vecs[3] = mk(K_INTA, 3'b000, 3'b111, 1'b0, 0, 1, 0, 3'b000);
        vecs[4] = mk(K_IOR,  3'b011, 3'b111, 1'b0, 0, 9, 1, 3'b100);
        vecs[5] = mk(K_IOR,  3'b011, 3'b011, 1'b0, 0, 2, 0, 3'b100);
        vecs[6] = mk(K_MEM,  3'b011, 3'b111, 1'b0, 7, 8, 0, 3'b100);
        vecs[7] = mk(K_MEM,  3'b000, 3'b000, 1'b0, 0, 1, 0, 3'b100);
        vecs[8] = mk(K_MEM,  3'b110, 3'b111, 1'b0, 0, 8, 1, 3'b001);
        vecs[9] = mk(K_IOW,  3'b111, 3'b111, 1'b0, 0, 2, 0, 3'b001);

        reset_n    = 1'b0;
        ready_in   = '1;
        ready_mask = '1;
        async_mode = 1'b0;
        drive_bus(K_IDLE);
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rdy", int'(RDY), 1);
        chk("reset_wait_active", int'(wait_active), 0);
        chk("reset_timeout_pulse", int'(timeout_pulse), 0);
        chk("reset_timeout_sources", int'(timeout_sources), 0);
        reset_n = 1'b1;
        wait_mid();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Bus goes idle while stuck in WAIT_EXT: back to IDLE, no timeout
        wait_mid();
        ready_in   = 3'b011;
        ready_mask = 3'b111;
        async_mode = 1'b0;
        wait_mid();
        drive_bus(K_MEM);
        repeat (3) wait_mid();
        chk("abort_wait_active_before", int'(wait_active), 1);
        chk("abort_rdy_before", int'(RDY), 0);
        drive_bus(K_IDLE);
        pulses = 0;
        for (int c = 0; c < 3 * CPU_DIV; c++) begin
            @(posedge clock);
            #1;
            if (timeout_pulse) pulses++;
        end
        chk("abort_timeout_pulses", pulses, 0);
        chk("abort_rdy_after", int'(RDY), 1);
        chk("abort_wait_active_after", int'(wait_active), 0);
        chk("abort_timeout_sources_kept", int'(timeout_sources), 1);

        // Reset asserted mid WAIT_EXT: outputs return to reset values immediately
        wait_mid();
        drive_bus(K_MEM);
        repeat (3) wait_mid();
        chk("rst_mid_wait_active_before", int'(wait_active), 1);
        chk("rst_mid_rdy_before", int'(RDY), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rdy", int'(RDY), 1);
        chk("rst_mid_wait_active", int'(wait_active), 0);
        chk("rst_mid_timeout_sources", int'(timeout_sources), 0);
        chk("rst_mid_timeout_pulse", int'(timeout_pulse), 0);
        drive_bus(K_IDLE);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) wait_mid();
        chk("rst_after_rdy", int'(RDY), 1);
        chk("rst_after_wait_active", int'(wait_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
